// File: rtl/pe_defs.sv
`default_nettype none
// ============================================================================
// Package     : pe_defs
// Description : Shared definitions for the PE core front end. Holds the
//               exception codes reported by the fetch stage and the state
//               encoding of the fetch PC generator.
// Contents    : EXC_W      - exception code width
//               EXC_ADEL   - address error on instruction fetch
//               EXC_NONE   - no exception
//               fetch_state_e - RST_WAIT / RUN / REDIR_PEND
// Revision    : 1.0 - initial release
// ============================================================================
package pe_defs;

   localparam int EXC_W = 5;

   localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
   localparam logic [EXC_W-1:0] EXC_NONE = 5'h1F;

   // RST_WAIT : single quiet cycle after reset release
   // RUN      : normal sequential fetching
   // REDIR_PEND: a redirect arrived while a request was stalled; the stalled
   //             request is still presented and will be killed on accept
   typedef enum logic [1:0] {
      RST_WAIT   = 2'd0,
      RUN        = 2'd1,
      REDIR_PEND = 2'd2
   } fetch_state_e;

   // Byte offset width of one aligned fetch block (4-byte instructions).
   function automatic int blk_off(input int fetch_width);
      return $clog2(fetch_width) + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_gen_if.sv
`default_nettype none
// ============================================================================
// Interface   : pc_fetch_gen_if
// Description : Fetch-request handshake and redirect bus between the PC
//               generator (master) and the fetch pipeline (slave).
// Signals     : fetch_enable        - pipeline allows a new request
//               fetch_valid/ready   - request handshake
//               fetch_pc/mask       - block address and valid slots
//               fetch_kill          - accepted request is stale
//               fetch_adel/excep_code - misaligned PC report
//               is_exception / is_excep_return / is_jump_branch + targets
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_gen_if #(
   parameter int ADDR_W      = 32,
   parameter int FETCH_WIDTH = 2
);
   import pe_defs::*;

   logic                   fetch_enable;
   logic                   fetch_valid;
   logic                   fetch_ready;
   logic [ADDR_W-1:0]      fetch_pc;
   logic [FETCH_WIDTH-1:0] fetch_mask;
   logic                   fetch_kill;
   logic                   fetch_adel;
   logic [EXC_W-1:0]       excep_code;
   logic                   is_exception;
   logic                   is_excep_return;
   logic [ADDR_W-1:0]      excep_return_pc;
   logic                   is_jump_branch;
   logic [ADDR_W-1:0]      jump_branch_address;

   // PC generator side
   modport master (
      input  fetch_enable,
      output fetch_valid,
      input  fetch_ready,
      output fetch_pc,
      output fetch_mask,
      output fetch_kill,
      output fetch_adel,
      output excep_code,
      input  is_exception,
      input  is_excep_return,
      input  excep_return_pc,
      input  is_jump_branch,
      input  jump_branch_address
   );

   // Fetch pipeline side
   modport slave (
      output fetch_enable,
      input  fetch_valid,
      output fetch_ready,
      input  fetch_pc,
      input  fetch_mask,
      input  fetch_kill,
      input  fetch_adel,
      input  excep_code,
      output is_exception,
      output is_excep_return,
      output excep_return_pc,
      output is_jump_branch,
      output jump_branch_address
   );

endinterface
`default_nettype wire

// File: rtl/pc_redirect_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_sel
// Description : Combinational redirect priority mux.
//               exception > exception-return > jump/branch.
// Ports       : i_is_exception      - redirect to EBASE_PC
//               i_is_excep_return   - redirect to i_excep_return_pc
//               i_excep_return_pc   - exception return target
//               i_is_jump_branch    - redirect to i_jump_branch_address
//               i_jump_branch_address - branch target
//               o_redir             - any redirect requested
//               o_target            - selected redirect target
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_sel #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] EBASE_PC = 32'hBFC0_0380
) (
   input  wire logic              i_is_exception,
   input  wire logic              i_is_excep_return,
   input  wire logic [ADDR_W-1:0] i_excep_return_pc,
   input  wire logic              i_is_jump_branch,
   input  wire logic [ADDR_W-1:0] i_jump_branch_address,
   output logic                   o_redir,
   output logic [ADDR_W-1:0]      o_target
);

   assign o_redir = i_is_exception | i_is_excep_return | i_is_jump_branch;

   always_comb begin
      o_target = i_jump_branch_address;
      if (i_is_exception) begin
         o_target = EBASE_PC;
      end else if (i_is_excep_return) begin
         o_target = i_excep_return_pc;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_gen
// Description : Program-counter and fetch-request generator for the PE core
//               front end. Holds the fetch PC, issues aligned blocks of
//               FETCH_WIDTH instructions over a valid/ready handshake and
//               applies prioritised redirects. A redirect that arrives while
//               a request is stalled is buffered, and the stalled request is
//               flagged as killed when it is finally accepted.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               io_fetch - pc_fetch_gen_if.master (handshake, PC, mask,
//                          kill, address error and redirect inputs)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen
   import pe_defs::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                FETCH_WIDTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC    = 32'hBFC0_0000,
   parameter logic [ADDR_W-1:0] EBASE_PC    = 32'hBFC0_0380
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   pc_fetch_gen_if.master   io_fetch
);

   localparam int OFF    = blk_off(FETCH_WIDTH);
   localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int BLK_W  = ADDR_W - OFF;

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] r_pend_pc;
   logic [ADDR_W-1:0] w_pend_nxt;
   logic              r_held;

   logic              w_redir;
   logic [ADDR_W-1:0] w_target;
   logic              w_valid;
   logic              w_accept;
   logic              w_stall;
   logic              w_kill;
   logic              w_adel;
   logic [SLOT_W-1:0] w_slot;
   logic [BLK_W-1:0]  w_blk_next;
   logic [ADDR_W-1:0] w_seq_pc;
   logic [FETCH_WIDTH-1:0] w_mask;

   // ------------------------------------------------------------------------
   // Redirect priority selection
   // ------------------------------------------------------------------------
   pc_redirect_sel #(
      .ADDR_W   (ADDR_W),
      .EBASE_PC (EBASE_PC)
   ) u_redirect_sel (
      .i_is_exception        (io_fetch.is_exception),
      .i_is_excep_return     (io_fetch.is_excep_return),
      .i_excep_return_pc     (io_fetch.excep_return_pc),
      .i_is_jump_branch      (io_fetch.is_jump_branch),
      .i_jump_branch_address (io_fetch.jump_branch_address),
      .o_redir               (w_redir),
      .o_target              (w_target)
   );

   // ------------------------------------------------------------------------
   // Handshake. Once a request is shown it is held until accepted, which is
   // why the pending state forces valid regardless of fetch_enable.
   // ------------------------------------------------------------------------
   assign w_valid  = (r_state == REDIR_PEND) |
                     ((r_state == RUN) & (io_fetch.fetch_enable | r_held));
   assign w_accept = w_valid & io_fetch.fetch_ready;
   assign w_stall  = w_valid & ~io_fetch.fetch_ready;
   assign w_kill   = w_accept & (w_redir | (r_state == REDIR_PEND));

   // Next aligned block: increment the block index, clear the offset bits.
   assign w_blk_next = r_pc[ADDR_W-1:OFF] + {{(BLK_W-1){1'b0}}, 1'b1};
   assign w_seq_pc   = {w_blk_next, {OFF{1'b0}}};

   // ------------------------------------------------------------------------
   // Slot index of the current PC inside its block
   // ------------------------------------------------------------------------
   generate
      if (FETCH_WIDTH > 1) begin : g_slot_multi
         assign w_slot = r_pc[OFF-1:2];
      end else begin : g_slot_single
         assign w_slot = '0;
      end
   endgenerate

   assign w_adel = |r_pc[1:0];

   // Slots before the entry point of the block are not part of the request.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         w_mask[i] = w_valid & ~w_adel & (i >= int'(w_slot));
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= RST_WAIT;
         r_pc      <= RESET_PC;
         r_pend_pc <= '0;
         r_held    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pend_pc <= w_pend_nxt;
         r_held    <= w_stall;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / next-PC logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_nxt  = r_pend_pc;
      case (r_state)
         RST_WAIT: begin
            w_state_nxt = RUN;
            if (w_redir) begin
               w_pc_nxt = w_target;
            end
         end
         RUN: begin
            if (w_redir) begin
               if (w_stall) begin
                  // The stalled request must stay stable; park the target.
                  w_pend_nxt  = w_target;
                  w_state_nxt = REDIR_PEND;
               end else begin
                  w_pc_nxt = w_target;
               end
            end else if (w_accept) begin
               w_pc_nxt = w_seq_pc;
            end
         end
         REDIR_PEND: begin
            if (w_accept) begin
               w_pc_nxt    = w_redir ? w_target : r_pend_pc;
               w_state_nxt = RUN;
            end else if (w_redir) begin
               // Newest redirect wins.
               w_pend_nxt = w_target;
            end
         end
         default: begin
            w_state_nxt = RST_WAIT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign io_fetch.fetch_valid = w_valid;
   assign io_fetch.fetch_pc    = r_pc;
   assign io_fetch.fetch_mask  = w_mask;
   assign io_fetch.fetch_kill  = w_kill;
   assign io_fetch.fetch_adel  = w_adel;
   assign io_fetch.excep_code  = w_adel ? EXC_ADEL : EXC_NONE;

endmodule
`default_nettype wire
